// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: word-aligned request with byte
// enables, a grant handshake and a separate read-data return.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment, issues one memory
// transaction per access and returns an extended load result or an exception.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] resp_pc,
    load_store_unit_if.master mem
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rdata_q;

    function automatic logic is_store(input logic [2:0] o);
        return o[2] & (o[1] | o[0]);
    endfunction

    function automatic logic misaligned(input logic [2:0] o, input logic [1:0] a);
        logic result;
        case (o)
            OP_LW, OP_SW:         result = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: result = a[0];
            default:              result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] o, input logic [1:0] a);
        logic [3:0] be;
        case (o)
            OP_LW, OP_SW:         be = 4'b1111;
            OP_LH, OP_LHU, OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
            default:              be = 4'b0001 << a;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] o, input logic [31:0] w);
        logic [31:0] d;
        case (o)
            OP_SW:   d = w;
            OP_SH:   d = {2{w[15:0]}};
            OP_SB:   d = {4{w[7:0]}};
            default: d = 32'h0;
        endcase
        return d;
    endfunction

    // Pick the addressed lane out of the returned word and extend it.
    function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] a,
                                            input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] result;
        shifted = word >> {a, 3'b000};
        half    = a[1] ? word[31:16] : word[15:0];
        case (o)
            OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  result = {24'h0, shifted[7:0]};
            OP_LH:   result = {{16{half[15]}}, half};
            OP_LHU:  result = {16'h0, half};
            default: result = word;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
                rdata_q <= 32'h0;
            end else if (state == WAIT && mem.mem_rvalid) begin
                rdata_q <= extract(op_q, addr_q[1:0], mem.mem_rdata);
            end
        end
    end

    // Bus fields are zero outside REQ; inside REQ they come from registers, so they stay stable.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        exc_adel      = 1'b0;
        exc_ades      = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'h0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = misaligned(op, addr[1:0]) ? ERR : REQ;
                end
            end
            REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = is_store(op_q);
                mem.mem_addr  = {addr_q[31:2], 2'b00};
                mem.mem_be    = byte_enables(op_q, addr_q[1:0]);
                mem.mem_wdata = lane_data(op_q, wdata_q);
                if (mem.mem_gnt) begin
                    state_next = is_store(op_q) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                exc_adel   = ~is_store(op_q);
                exc_ades   = is_store(op_q);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdata   = rdata_q;
    assign resp_pc = pc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: stores, extending loads, grant
// stalls, misalignment exceptions, reset abort and back-to-back requests.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] resp_pc;

    int tests_run;
    int tests_failed;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .pc         (pc),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .resp_pc    (resp_pc),
        .mem        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one request for a single cycle; returns in the cycle after the accept edge.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] w, input logic [31:0] p);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        wdata     = w;
        pc        = p;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        req_valid      = 1'b0;
        op             = 3'b000;
        addr           = 32'h0;
        wdata          = 32'h0;
        pc             = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);

        check_output("reset req_ready", {31'h0, req_ready}, 32'h1);
        check_output("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check_output("reset exc", {30'h0, exc_adel, exc_ades}, 32'h0);
        check_output("reset rdata", rdata, 32'h0);
        check_output("reset resp_pc", resp_pc, 32'h0);
        check_output("reset mem_req/we", {30'h0, bus.mem_req, bus.mem_we}, 32'h0);
        check_output("reset mem_be", {28'h0, bus.mem_be}, 32'h0);
        check_output("reset mem_addr", bus.mem_addr, 32'h0);
        check_output("reset mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // sb to byte 3 with immediate grant
        bus.mem_gnt = 1'b1;
        apply_stimulus(3'b111, 32'h0000_0013, 32'h0000_00A5, 32'h0000_1000);
        check_output("sb mem_req", {31'h0, bus.mem_req}, 32'h1);
        check_output("sb mem_we", {31'h0, bus.mem_we}, 32'h1);
        check_output("sb mem_addr", bus.mem_addr, 32'h0000_0010);
        check_output("sb mem_be", {28'h0, bus.mem_be}, 32'h8);
        check_output("sb mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        check_output("sb req_ready busy", {31'h0, req_ready}, 32'h0);
        check_output("sb no early resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check_output("sb resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("sb exc", {30'h0, exc_adel, exc_ades}, 32'h0);
        check_output("sb rdata", rdata, 32'h0);
        check_output("sb resp_pc", resp_pc, 32'h0000_1000);
        check_output("sb mem_req after gnt", {31'h0, bus.mem_req}, 32'h0);
        check_output("sb req_ready during resp", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check_output("sb resp one cycle", {31'h0, resp_valid}, 32'h0);
        check_output("sb back to idle", {31'h0, req_ready}, 32'h1);

        // sh to upper half
        apply_stimulus(3'b110, 32'h0000_0022, 32'hABCD_1234, 32'h0000_1004);
        check_output("sh mem_be", {28'h0, bus.mem_be}, 32'hC);
        check_output("sh mem_wdata", bus.mem_wdata, 32'h1234_1234);
        check_output("sh mem_addr", bus.mem_addr, 32'h0000_0020);
        @(negedge clk);
        check_output("sh resp_valid", {31'h0, resp_valid}, 32'h1);
        @(negedge clk);

        // lb byte 2, sign-extended
        apply_stimulus(3'b011, 32'h0000_0002, 32'h0, 32'h0000_1008);
        check_output("lb mem_be", {28'h0, bus.mem_be}, 32'h4);
        check_output("lb mem_we", {31'h0, bus.mem_we}, 32'h0);
        check_output("lb mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        check_output("lb wait no req", {31'h0, bus.mem_req}, 32'h0);
        check_output("lb wait no resp", {31'h0, resp_valid}, 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12F4_5678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("lb resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("lb rdata", rdata, 32'hFFFF_FFF4);
        check_output("lb resp_pc", resp_pc, 32'h0000_1008);
        @(negedge clk);

        // lbu same access, zero-extended
        apply_stimulus(3'b100, 32'h0000_0002, 32'h0, 32'h0000_100C);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("lbu resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("lbu rdata", rdata, 32'h0000_00F4);
        @(negedge clk);

        // lh upper half, sign-extended
        apply_stimulus(3'b001, 32'h0000_0006, 32'h0, 32'h0000_1010);
        check_output("lh mem_be", {28'h0, bus.mem_be}, 32'hC);
        check_output("lh mem_addr", bus.mem_addr, 32'h0000_0004);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h8001_0000;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("lh rdata", rdata, 32'hFFFF_8001);
        @(negedge clk);

        // lhu lower half, zero-extended
        apply_stimulus(3'b010, 32'h0000_0004, 32'h0, 32'h0000_1014);
        check_output("lhu mem_be", {28'h0, bus.mem_be}, 32'h3);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_9ABC;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("lhu rdata", rdata, 32'h0000_9ABC);
        @(negedge clk);

        // lw with grant stalled three cycles; a stray rvalid during REQ must be ignored
        bus.mem_gnt = 1'b0;
        apply_stimulus(3'b000, 32'h0000_0020, 32'h0, 32'h0000_1018);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            check_output("lw stall mem_req", {31'h0, bus.mem_req}, 32'h1);
            check_output("lw stall mem_addr", bus.mem_addr, 32'h0000_0020);
            check_output("lw stall mem_be", {28'h0, bus.mem_be}, 32'hF);
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        check_output("lw 4th req cycle", {31'h0, bus.mem_req}, 32'h1);
        check_output("lw 4th mem_addr", bus.mem_addr, 32'h0000_0020);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check_output("lw req dropped after gnt", {31'h0, bus.mem_req}, 32'h0);
        @(negedge clk);
        check_output("lw still waiting", {31'h0, resp_valid}, 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("lw resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("lw rdata", rdata, 32'hDEAD_BEEF);
        check_output("lw resp_pc", resp_pc, 32'h0000_1018);
        @(negedge clk);

        // misaligned sw -> store exception, no memory request
        bus.mem_gnt = 1'b1;
        apply_stimulus(3'b101, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0000_101C);
        check_output("sw misalign resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("sw misalign exc_ades", {31'h0, exc_ades}, 32'h1);
        check_output("sw misalign exc_adel", {31'h0, exc_adel}, 32'h0);
        check_output("sw misalign mem_req", {31'h0, bus.mem_req}, 32'h0);
        check_output("sw misalign rdata", rdata, 32'h0);
        check_output("sw misalign resp_pc", resp_pc, 32'h0000_101C);
        @(negedge clk);
        check_output("sw misalign back idle", {30'h0, req_ready, resp_valid}, 32'h2);
        check_output("sw misalign never req", {31'h0, bus.mem_req}, 32'h0);

        // misaligned lh -> load exception
        apply_stimulus(3'b001, 32'h0000_0001, 32'h0, 32'h0000_1020);
        check_output("lh misalign exc_adel", {31'h0, exc_adel}, 32'h1);
        check_output("lh misalign exc_ades", {31'h0, exc_ades}, 32'h0);
        check_output("lh misalign resp_valid", {31'h0, resp_valid}, 32'h1);
        @(negedge clk);

        // reset while waiting for read data, then a stray rvalid
        apply_stimulus(3'b000, 32'h0000_0040, 32'h0, 32'h0000_1024);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        check_output("abort wait req_ready", {31'h0, req_ready}, 32'h1);
        check_output("abort wait resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("abort stray rvalid resp", {31'h0, resp_valid}, 32'h0);
        check_output("abort stray rvalid rdata", rdata, 32'h0);
        check_output("abort still idle", {31'h0, req_ready}, 32'h1);

        // reset while stalled in REQ drops mem_req
        bus.mem_gnt = 1'b0;
        apply_stimulus(3'b101, 32'h0000_0080, 32'h1, 32'h0000_1028);
        check_output("abort req mem_req before", {31'h0, bus.mem_req}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort req mem_req", {31'h0, bus.mem_req}, 32'h0);
        @(negedge clk);
        check_output("abort req no resp", {31'h0, resp_valid}, 32'h0);

        // back-to-back sw then lw with req_valid held high
        bus.mem_gnt = 1'b1;
        req_valid   = 1'b1;
        op          = 3'b101;
        addr        = 32'h0000_0200;
        wdata       = 32'h1122_3344;
        pc          = 32'h0000_2000;
        @(negedge clk);
        op    = 3'b000;
        addr  = 32'h0000_0204;
        wdata = 32'h0;
        pc    = 32'h0000_2004;
        check_output("b2b sw mem_wdata", bus.mem_wdata, 32'h1122_3344);
        check_output("b2b busy in req", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check_output("b2b sw resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("b2b sw resp_pc", resp_pc, 32'h0000_2000);
        check_output("b2b no accept on resp", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check_output("b2b idle ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("b2b lw mem_addr", bus.mem_addr, 32'h0000_0204);
        check_output("b2b lw mem_we", {31'h0, bus.mem_we}, 32'h0);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_output("b2b lw resp_valid", {31'h0, resp_valid}, 32'h1);
        check_output("b2b lw resp_pc", resp_pc, 32'h0000_2004);
        check_output("b2b lw rdata", rdata, 32'hCAFE_F00D);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have req_valid  in  1  pipeline access request; req_ready  out  1  unit can accept a request.
REQ-003 SHALL have op  in  3  access type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
REQ-004 SHALL have addr  in  32  byte address; wdata  in  32  store data in the low bits; pc  in  32  instruction PC.
REQ-005 SHALL have resp_valid  out  1  one-cycle completion pulse; rdata  out  32  extended load result; exc_adel  out  1  load misaligned; exc_ades  out  1  store misaligned; resp_pc  out  32  PC of the completing access.
REQ-006 SHALL have mem_req  out  1; mem_we  out  1; mem_addr  out  32, word-aligned; mem_be  out  4, byte enables; mem_wdata  out  32, lane-aligned.
REQ-007 SHALL have mem_gnt  in  1  request accepted; mem_rvalid  in  1  read data valid; mem_rdata  in  32  read word.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, RESP, ERR.
REQ-009 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready, op/addr/wdata/pc SHALL be registered.
REQ-010 SHALL treat an access as misaligned when: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]=1. Byte accesses are never misaligned.
REQ-011 On accepting a misaligned access, the FSM SHALL go IDLE->ERR with no memory request; ERR SHALL assert resp_valid=1 for one cycle, with exc_adel (load op) or exc_ades (store op), rdata=0; then go to IDLE.
REQ-012 On accepting an aligned access, the FSM SHALL go IDLE->REQ; in REQ, mem_req=1 SHALL be held with stable mem_* outputs until mem_gnt=1.
REQ-013 SHALL drive mem_addr={addr[31:2],2'b00} and mem_we=1 for store ops.
REQ-014 SHALL drive mem_be: word 1111; half 0011 (addr[1]=0) or 1100; byte 0001<<addr[1:0]; loads SHALL drive the same be pattern.
REQ-015 SHALL drive mem_wdata: sw wdata; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
REQ-016 On REQ&&mem_gnt: a store SHALL go to RESP; a load SHALL go to WAIT.
REQ-017 In WAIT, on mem_rvalid, the unit SHALL capture the extracted result into rdata and go to RESP. mem_rvalid SHALL be ignored in every other state.
REQ-018 Extraction SHALL work as follows. lw: whole word. lb/lbu: byte addr[1:0] (bits 8k+7:8k), sign-extended or zero-extended. lh/lhu: half addr[1] (bits 15:0 or 31:16), sign-extended or zero-extended.
REQ-019 RESP SHALL assert resp_valid=1 for exactly one cycle with exc_* = 0, then go to IDLE. For stores, rdata=0.
REQ-020 resp_pc SHALL equal the registered pc whenever resp_valid=1.
REQ-021 Minimum latency, counted from the accept edge: store 2 cycles (grant in first REQ cycle); load 3 cycles (rvalid in first WAIT cycle); misaligned 1 cycle.
REQ-022 mem_gnt stall cycles and mem_rvalid wait cycles SHALL be unbounded; no timeout.
REQ-023 Outside REQ: mem_req=0 and mem_we=0. resp_valid SHALL be 0 outside RESP/ERR.
REQ-024 A new request SHALL NOT be accepted in the same cycle as resp_valid; it is accepted no earlier than the following IDLE cycle.

Reset
REQ-025 On reset: state=IDLE, req_ready=1, resp_valid=0, exc_adel=0, exc_ades=0, rdata=0, resp_pc=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset asserted mid-operation (REQ or WAIT) SHALL abort the access and deassert mem_req at that edge. No resp_valid SHALL follow, and a later stray mem_rvalid SHALL be ignored.

Verification
REQ-027 sb op=111, addr=0x00000013, wdata=0x000000A5, mem_gnt=1 -> mem_addr=0x10, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid 2 cycles after accept.
REQ-028 lb addr=0x00000002, mem_rdata=0x12F4_5678 -> rdata=0xFFFFFFF4. Same access as lbu -> rdata=0x000000F4.
REQ-029 lh addr=0x00000006, mem_rdata=0x8001_0000 -> mem_be=1100, rdata=0xFFFF8001. lw with mem_gnt delayed 3 cycles -> mem_req held 4 cycles with stable mem_addr.
REQ-030 sw addr=0x00000102 -> ERR, resp_valid=1, exc_ades=1, mem_req never asserted. lh addr=0x00000001 -> exc_adel=1.
REQ-031 Reset asserted while in WAIT, followed by mem_rvalid=1 -> no resp_valid, state IDLE, req_ready=1.
REQ-032 Back-to-back: req_valid held high for sw then lw -> second accept occurs only after resp_valid of the first, and resp_pc matches each pc in order.
